fetch_sequencer: RTL and testbench

- Controls the instruction-fetch stage.
- Owns the program counter and issues word-indexed requests to instruction memory over a req/ack handshake.
- Loads the 64-bit IF_ID latch as {pc, instruction}.
- Honours back-pressure from decode and applies branch redirects with a flush of IF_ID and of any in-flight fetch.
- Sits between the instruction memory and the decode stage; it replaces the free-running pc increment.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_perf_ctr.sv | 32 +++
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// FETCH_PERF_EN (see fetch_sequencer.sv) adds the optional performance counters.
package fetch_pkg;

   localparam int                   PC_W_DEF     = 32;
   localparam int                   INSTR_W_DEF  = 32;
   localparam longint unsigned      RESET_PC_DEF = 64'd0;

   typedef enum logic [1:0] {
      RESET_ST = 2'd0,
      REQ      = 2'd1,
      WAIT_ID  = 2'd2,
      DRAIN    = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } if_id_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating fetch/stall event counters for the fetch sequencer.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_ctr (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_fetch_inc,
   input  logic        i_stall_inc,
   output logic [31:0] o_fetched,
   output logic [31:0] o_stall_cycles
);

   logic [31:0] r_fetched;
   logic [31:0] r_stall_cycles;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetched      <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (i_fetch_inc) r_fetched      <= sat_inc(r_fetched);
         if (i_stall_inc) r_stall_cycles <= sat_inc(r_stall_cycles);
      end
   end

   assign o_fetched      = r_fetched;
   assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the pc, runs the imem req/ack handshake and fills IF_ID.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall_cycles counter outputs.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      branch_flag,
   input  logic [PC_W-1:0]           branch_target,
   input  logic                      id_stall,
   output logic                      imem_req,
   output logic [PC_W-1:0]           imem_addr,
   input  logic                      imem_ack,
   input  logic [INSTR_W-1:0]        imem_rdata,
   output logic [PC_W+INSTR_W-1:0]   IF_ID,
   output logic                      if_id_valid,
   output logic [PC_W-1:0]           pc
`ifdef FETCH_PERF_EN
  ,output logic [31:0]               perf_fetched,
   output logic [31:0]               perf_stall_cycles
`endif
);

   fetch_state_t                r_state;
   fetch_state_t                w_state_nxt;
   logic [PC_W-1:0]             r_pc;
   logic [PC_W-1:0]             w_pc_nxt;
   logic [PC_W-1:0]             r_addr;
   logic [PC_W+INSTR_W-1:0]     r_if_id;
   logic [PC_W+INSTR_W-1:0]     r_skid;
   logic                        r_vld;

   logic                        w_req;
   logic                        w_branch;
   logic                        w_busy;
   logic                        w_load_mem;
   logic                        w_load_skid;
   logic                        w_capture;
   logic                        w_load;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= RESET_ST;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; a branch never abandons an open handshake, it drains it
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RESET_ST: w_state_nxt = REQ;
         REQ: begin
            if (w_branch)              w_state_nxt = imem_ack ? REQ : DRAIN;
            else if (imem_ack && w_busy) w_state_nxt = WAIT_ID;
         end
         WAIT_ID: begin
            if (w_branch || !id_stall) w_state_nxt = REQ;
         end
         DRAIN: begin
            if (imem_ack)              w_state_nxt = REQ;
         end
         default: w_state_nxt = RESET_ST;
      endcase
   end

   // Output / event decode
   always_comb begin
      w_req       = (r_state == REQ) || (r_state == DRAIN);
      w_branch    = branch_flag && (r_state != RESET_ST);
      w_busy      = r_vld && id_stall;
      w_load_mem  = (r_state == REQ) && imem_ack && !w_busy && !w_branch;
      w_capture   = (r_state == REQ) && imem_ack &&  w_busy && !w_branch;
      w_load_skid = (r_state == WAIT_ID) && !id_stall && !w_branch;
      w_load      = w_load_mem || w_load_skid;
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (w_branch)    w_pc_nxt = branch_target;
      else if (w_load) w_pc_nxt = r_pc + PC_W'(1);
   end

   // Datapath: pc, request address and the IF_ID latch
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_if_id <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_state_nxt == REQ) r_addr <= w_pc_nxt;
         if (w_load_mem)       r_if_id <= {r_pc, imem_rdata};
         else if (w_load_skid) r_if_id <= r_skid;
         if (w_branch)         r_vld <= 1'b0;
         else if (w_load)      r_vld <= 1'b1;
         else if (!id_stall)   r_vld <= 1'b0;
      end
   end

   // Skid slot is only meaningful in WAIT_ID, so it needs no reset
   always_ff @(posedge clock) begin
      if (w_capture) r_skid <= {r_pc, imem_rdata};
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_addr;
   assign IF_ID       = r_if_id;
   assign if_id_valid = r_vld;
   assign pc          = r_pc;

`ifdef FETCH_PERF_EN
   fetch_perf_ctr u_perf (
      .clock          (clock),
      .reset          (reset),
      .i_fetch_inc    (w_load),
      .i_stall_inc    ((r_state == WAIT_ID) || (w_req && !imem_ack)),
      .o_fetched      (perf_fetched),
      .o_stall_cycles (perf_stall_cycles)
   );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected IF_ID words,
// a monitor pops and compares each instruction as decode consumes it.
module tb_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [63:0] IF_ID;
   logic        if_id_valid;
   logic [31:0] pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb_q[$];

   int          budget    = 0;
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic        force_ack = 1'b0;

   fetch_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .id_stall      (id_stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .IF_ID         (IF_ID),
      .if_id_valid   (if_id_valid),
      .pc            (pc)
`ifdef FETCH_PERF_EN
     ,.perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      sb_q.push_back({a, instr_of(a)});
   endtask

   // Memory model: acks a bounded number of requests after ack_delay wait cycles
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clock);
         if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
            wait_cnt   = 0;
         end else if (imem_req && budget > 0) begin
            if (wait_cnt >= ack_delay) begin
               imem_ack   = 1'b1;
               imem_rdata = instr_of(imem_addr);
               wait_cnt   = 0;
               budget--;
            end else begin
               imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            if (!imem_req) wait_cnt = 0;
         end
      end
   end

   // Monitor: decode consumes IF_ID whenever it is valid and not stalled
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clock);
         if (!reset && if_id_valid && !id_stall) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got %h expected none", IF_ID);
            end else begin
               exp = sb_q.pop_front();
               chk("sb_ifid", IF_ID, exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      branch_flag   = 1'b0;
      branch_target = '0;
      id_stall      = 1'b0;

      tick(3);
      chk("rst_req",   {63'd0, imem_req},    64'd0);
      chk("rst_vld",   {63'd0, if_id_valid}, 64'd0);
      chk("rst_ifid",  IF_ID,                64'd0);
      chk("rst_pc",    {32'd0, pc},          64'd0);

      // Streaming fetch, one ack per cycle
      push(32'd0); push(32'd1); push(32'd2);
      budget = 3;
      reset  = 1'b0;
      tick(1);
      chk("req_up",    {63'd0, imem_req},    64'd1);
      chk("req_addr0", {32'd0, imem_addr},   64'd0);
      tick(1);
      chk("vld_first", {63'd0, if_id_valid}, 64'd1);
      chk("ifid_first", IF_ID, {32'd0, instr_of(32'd0)});
      tick(4);
      chk("stream_pc",  {32'd0, pc},          64'd3);
      chk("stream_vld", {63'd0, if_id_valid}, 64'd0);

      // Back-pressure with skid capture
      id_stall = 1'b1;
      budget   = 3;
      push(32'd3); push(32'd4); push(32'd5);
      tick(2);
      chk("wait_req",   {63'd0, imem_req}, 64'd0);
      chk("stall_hold", IF_ID, {32'd3, instr_of(32'd3)});
      tick(1);
      chk("stall_hold2", IF_ID, {32'd3, instr_of(32'd3)});
      chk("stall_vld",  {63'd0, if_id_valid}, 64'd1);
      id_stall = 1'b0;
      tick(5);
      chk("skid_pc",    {32'd0, pc}, 64'd6);

      // Branch while the request is waiting: drain the old address
      ack_delay     = 2;
      budget        = 2;
      push(32'h40);
      branch_flag   = 1'b1;
      branch_target = 32'h40;
      tick(1);
      branch_flag   = 1'b0;
      chk("br_flush",   {63'd0, if_id_valid}, 64'd0);
      chk("br_pc",      {32'd0, pc},          64'h40);
      chk("drain_addr", {32'd0, imem_addr},   64'd6);
      chk("drain_req",  {63'd0, imem_req},    64'd1);
      tick(1);
      chk("drain_addr2", {32'd0, imem_addr},  64'd6);
      tick(8);
      chk("br_pc_after", {32'd0, pc},         64'h41);

      // Branch coincident with ack
      ack_delay     = 0;
      budget        = 1;
      branch_flag   = 1'b1;
      branch_target = 32'h80;
      tick(1);
      branch_flag   = 1'b0;
      chk("brack_addr", {32'd0, imem_addr},   64'h80);
      chk("brack_pc",   {32'd0, pc},          64'h80);
      chk("brack_vld",  {63'd0, if_id_valid}, 64'd0);
      push(32'h80);
      budget = 1;
      tick(4);
      chk("brack_pc2",  {32'd0, pc},          64'h81);

      // Reset during DRAIN with the ack still pending, then a late ack
      ack_delay     = 2;
      budget        = 1;
      branch_flag   = 1'b1;
      branch_target = 32'h100;
      tick(1);
      branch_flag   = 1'b0;
      chk("rd_drain_addr", {32'd0, imem_addr}, 64'h81);
      reset = 1'b1;
      tick(1);
      chk("rd_req",  {63'd0, imem_req},    64'd0);
      chk("rd_vld",  {63'd0, if_id_valid}, 64'd0);
      chk("rd_ifid", IF_ID,                64'd0);
      chk("rd_pc",   {32'd0, pc},          64'd0);
      reset     = 1'b0;
      budget    = 0;
      force_ack = 1'b1;
      tick(1);
      force_ack = 1'b0;
      chk("late_ifid", IF_ID,                64'd0);
      chk("late_vld",  {63'd0, if_id_valid}, 64'd0);
      chk("late_pc",   {32'd0, pc},          64'd0);
      chk("late_addr", {32'd0, imem_addr},   64'd0);
      chk("late_req",  {63'd0, imem_req},    64'd1);
      ack_delay = 0;
      push(32'd0);
      budget = 1;
      tick(4);

      // pc wrap at the top of the address space
      branch_flag   = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      tick(1);
      branch_flag   = 1'b0;
      push(32'hFFFF_FFFF); push(32'd0);
      budget = 3;
      tick(6);
      chk("wrap_pc", {32'd0, pc}, 64'd1);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", {32'd0, perf_fetched}, 64'd3);
`endif

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
